// File: rtl/bram_arb_pkg.sv
// Shared types for the two-requester BRAM port arbiter: default widths,
// requester id and the command bundle carried through the BRAM stage.
package bram_arb_pkg;

    localparam int ARB_ADDR_WIDTH = 10;
    localparam int ARB_DATA_WIDTH = 32;
    localparam int ARB_STRB_WIDTH = ARB_DATA_WIDTH / 8;

    typedef logic req_id_t;

    // Field widths follow the package defaults; the top module's parameters
    // default to the same values.
    typedef struct packed {
        logic                      we;
        logic [ARB_ADDR_WIDTH-1:0] addr;
        logic [ARB_DATA_WIDTH-1:0] wdata;
        logic [ARB_STRB_WIDTH-1:0] wstrb;
    } bram_cmd_t;

    function automatic bram_cmd_t pick_cmd(input req_id_t id,
                                           input bram_cmd_t cmd0,
                                           input bram_cmd_t cmd1);
        return id ? cmd1 : cmd0;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_rr.sv
// Two-way round-robin grant: combinational grant, registered priority pointer
// that flips only when a contested grant is issued.
module rr_arbiter2
    import bram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output req_id_t    gnt_id
);

    logic favour;

    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        if (!rst) begin
            if (req[0] && (!req[1] || !favour)) begin
                gnt    = 2'b01;
                gnt_id = 1'b0;
            end else if (req[1]) begin
                gnt    = 2'b10;
                gnt_id = 1'b1;
            end
        end
    end

    // After a contested grant the loser gets priority next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            favour <= 1'b0;
        end else if (req == 2'b11) begin
            favour <= ~gnt_id;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between two requesters: round-robin grant, a registered
// BRAM command stage and a two-stage read-return pipeline tagged by requester.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    req0_i,
    input  logic                    we0_i,
    input  logic [ADDR_WIDTH-1:0]   addr0_i,
    input  logic [DATA_WIDTH-1:0]   wdata0_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb0_i,
    input  logic                    req1_i,
    input  logic                    we1_i,
    input  logic [ADDR_WIDTH-1:0]   addr1_i,
    input  logic [DATA_WIDTH-1:0]   wdata1_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb1_i,
    output logic                    gnt0_o,
    output logic                    gnt1_o,
    output logic                    rvalid0_o,
    output logic                    rvalid1_o,
    output logic [DATA_WIDTH-1:0]   rdata0_o,
    output logic [DATA_WIDTH-1:0]   rdata1_o,
    output logic                    bram_en_o,
    output logic [DATA_WIDTH/8-1:0] bram_we_o,
    output logic [ADDR_WIDTH-1:0]   bram_addr_o,
    output logic [DATA_WIDTH-1:0]   bram_din_o,
    input  logic [DATA_WIDTH-1:0]   bram_dout_i
);

    logic [1:0]            gnt;
    req_id_t               gnt_id;
    bram_cmd_t             cmd0;
    bram_cmd_t             cmd1;
    bram_cmd_t             cmd_p0;

    logic                  vld_p1;
    req_id_t               id_p1;
    bram_cmd_t             cmd_p1;

    logic                  vld_p2;
    req_id_t               id_p2;

    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    rr_arbiter2 u_rr_arbiter2 (
        .clk    (ACLK),
        .rst    (ARESET),
        .req    ({req1_i, req0_i}),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign gnt0_o = gnt[0];
    assign gnt1_o = gnt[1];

    // Stage p0: granted command selected combinationally.
    assign cmd0   = '{we: we0_i, addr: addr0_i, wdata: wdata0_i, wstrb: wstrb0_i};
    assign cmd1   = '{we: we1_i, addr: addr1_i, wdata: wdata1_i, wstrb: wstrb1_i};
    assign cmd_p0 = pick_cmd(gnt_id, cmd0, cmd1);

    // Stage p1: command presented to the BRAM.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= |gnt;
        end
    end

    always_ff @(posedge ACLK) begin
        id_p1  <= gnt_id;
        cmd_p1 <= cmd_p0;
    end

    assign bram_en_o   = vld_p1 && !ARESET;
    assign bram_we_o   = (bram_en_o && cmd_p1.we) ? cmd_p1.wstrb : '0;
    assign bram_addr_o = ARESET ? '0 : cmd_p1.addr;
    assign bram_din_o  = ARESET ? '0 : cmd_p1.wdata;

    // Stage p2: BRAM read data returns to the owning requester.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1 && !cmd_p1.we;
        end
    end

    always_ff @(posedge ACLK) begin
        id_p2 <= id_p1;
    end

    assign rvalid0   = vld_p2 && (id_p2 == 1'b0) && !ARESET;
    assign rvalid1   = vld_p2 && (id_p2 == 1'b1) && !ARESET;
    assign rvalid0_o = rvalid0;
    assign rvalid1_o = rvalid1;

    // Read data passes straight through on the valid cycle and is held after.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rvalid0) begin
                rdata0_q <= bram_dout_i;
            end
            if (rvalid1) begin
                rdata1_q <= bram_dout_i;
            end
        end
    end

    assign rdata0_o = ARESET ? '0 : (rvalid0 ? bram_dout_i : rdata0_q);
    assign rdata1_o = ARESET ? '0 : (rvalid1 ? bram_dout_i : rdata1_q);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_bram_port_arbiter;
    import bram_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          req0_i, we0_i, req1_i, we1_i;
    logic [AW-1:0] addr0_i, addr1_i;
    logic [DW-1:0] wdata0_i, wdata1_i;
    logic [SW-1:0] wstrb0_i, wstrb1_i;
    logic          gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
    logic [DW-1:0] rdata0_o, rdata1_o;
    logic          bram_en_o;
    logic [SW-1:0] bram_we_o;
    logic [AW-1:0] bram_addr_o;
    logic [DW-1:0] bram_din_o;
    logic [DW-1:0] bram_dout_i;

    always #5 ACLK = ~ACLK;

    bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i), .wstrb0_i(wstrb0_i),
        .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i), .wstrb1_i(wstrb1_i),
        .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .rvalid0_o(rvalid0_o), .rvalid1_o(rvalid1_o),
        .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
        .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_addr_o(bram_addr_o),
        .bram_din_o(bram_din_o), .bram_dout_i(bram_dout_i)
    );

    // Synchronous BRAM with byte write enables and one-cycle read latency.
    logic [DW-1:0] bram_mem [0:(1<<AW)-1];
    always @(posedge ACLK) begin
        if (bram_en_o) begin
            for (int b = 0; b < SW; b++)
                if (bram_we_o[b]) bram_mem[bram_addr_o][8*b +: 8] <= bram_din_o[8*b +: 8];
            bram_dout_i <= bram_mem[bram_addr_o];
        end
    end

    typedef struct { bram_cmd_t c; bit id; } pend_t;
    typedef struct { bit id; logic [DW-1:0] d; } rd_t;

    pend_t         pend_bram [int];
    rd_t           pend_rd [int];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            mptr;
    logic [DW-1:0] last0, last1, obs_rd1;
    int            cyc, n_chk, n_err, rv0_cnt, rv1_cnt;
    bram_cmd_t     q0[$], q1[$];
    bit            act0, act1, gaps;
    int            glog[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bram_cmd_t mk(input bit we, input int addr, input logic [DW-1:0] d,
                                     input logic [SW-1:0] s);
        bram_cmd_t c;
        c.we = we; c.addr = AW'(addr); c.wdata = d; c.wstrb = s;
        return c;
    endfunction

    // Reference: grant rule, one-cycle command latency, read data one cycle later.
    task automatic check_cycle();
        bit eg0, eg1;
        pend_t p;
        rd_t r;
        if (ARESET) begin
            check("rst_gnt", 64'({gnt1_o, gnt0_o}), 64'(0));
            check("rst_rvalid", 64'({rvalid1_o, rvalid0_o}), 64'(0));
            check("rst_rdata0", 64'(rdata0_o), 64'(0));
            check("rst_rdata1", 64'(rdata1_o), 64'(0));
            check("rst_bram_en_we", 64'({bram_en_o, bram_we_o}), 64'(0));
            check("rst_bram_addr", 64'(bram_addr_o), 64'(0));
            check("rst_bram_din", 64'(bram_din_o), 64'(0));
            pend_bram.delete(); pend_rd.delete();
            mptr = 1'b0; last0 = '0; last1 = '0;
            return;
        end
        eg0 = req0_i && (!req1_i || !mptr);
        eg1 = req1_i && !eg0;
        check("gnt0", 64'(gnt0_o), 64'(eg0));
        check("gnt1", 64'(gnt1_o), 64'(eg1));
        if (pend_bram.exists(cyc)) begin
            p = pend_bram[cyc];
            pend_bram.delete(cyc);
            check("bram_en", 64'(bram_en_o), 64'(1));
            check("bram_addr", 64'(bram_addr_o), 64'(p.c.addr));
            if (p.c.we) begin
                check("bram_we", 64'(bram_we_o), 64'(p.c.wstrb));
                check("bram_din", 64'(bram_din_o), 64'(p.c.wdata));
                for (int b = 0; b < SW; b++)
                    if (p.c.wstrb[b]) ref_mem[p.c.addr][8*b +: 8] = p.c.wdata[8*b +: 8];
            end else begin
                check("bram_we_rd", 64'(bram_we_o), 64'(0));
                r.id = p.id; r.d = ref_mem[p.c.addr];
                pend_rd[cyc+1] = r;
            end
        end else begin
            check("bram_idle", 64'({bram_en_o, bram_we_o}), 64'(0));
        end
        if (pend_rd.exists(cyc)) begin
            r = pend_rd[cyc];
            pend_rd.delete(cyc);
            check("rvalid0", 64'(rvalid0_o), 64'(!r.id));
            check("rvalid1", 64'(rvalid1_o), 64'(r.id));
            if (r.id) last1 = r.d; else last0 = r.d;
        end else begin
            check("rvalid_idle", 64'({rvalid1_o, rvalid0_o}), 64'(0));
        end
        check("rdata0", 64'(rdata0_o), 64'(last0));
        check("rdata1", 64'(rdata1_o), 64'(last1));
        if (eg0 || eg1) begin
            p.id = eg1;
            p.c  = eg1 ? mk(we1_i, int'(addr1_i), wdata1_i, wstrb1_i)
                       : mk(we0_i, int'(addr0_i), wdata0_i, wstrb0_i);
            pend_bram[cyc+1] = p;
            if (req0_i && req1_i) mptr = eg0;
        end
    endtask

    task automatic drive();
        if (!act0 && q0.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) act0 = 1'b1;
        if (!act1 && q1.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) act1 = 1'b1;
        req0_i = act0;
        req1_i = act1;
        if (act0) begin
            we0_i = q0[0].we; addr0_i = q0[0].addr; wdata0_i = q0[0].wdata; wstrb0_i = q0[0].wstrb;
        end else begin
            we0_i = 1'($urandom); addr0_i = AW'($urandom); wdata0_i = $urandom; wstrb0_i = SW'($urandom);
        end
        if (act1) begin
            we1_i = q1[0].we; addr1_i = q1[0].addr; wdata1_i = q1[0].wdata; wstrb1_i = q1[0].wstrb;
        end else begin
            we1_i = 1'($urandom); addr1_i = AW'($urandom); wdata1_i = $urandom; wstrb1_i = SW'($urandom);
        end
    endtask

    task automatic step();
        bram_cmd_t tmp;
        drive();
        @(negedge ACLK);
        check_cycle();
        if (rvalid0_o) rv0_cnt++;
        if (rvalid1_o) begin rv1_cnt++; obs_rd1 = rdata1_o; end
        if (gnt0_o) begin
            glog.push_back(0);
            if (act0) begin tmp = q0.pop_front(); act0 = 1'b0; end
        end
        if (gnt1_o) begin
            glog.push_back(1);
            if (act1) begin tmp = q1.pop_front(); act1 = 1'b0; end
        end
        @(posedge ACLK); #1;
        cyc++;
    endtask

    task automatic drain(input int extra);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 200) begin step(); n++; end
        check("drain_timeout", 64'(q0.size() + q1.size()), 64'(0));
        repeat (extra) step();
    endtask

    task automatic reset_for(input int n);
        ARESET = 1'b1;
        repeat (n) step();
        ARESET = 1'b0;
    endtask

    initial begin
        int c0, c1, rv_before;
        for (int i = 0; i < (1 << AW); i++) begin bram_mem[i] = '0; ref_mem[i] = '0; end
        bram_dout_i = '0;
        ARESET = 1'b1; act0 = 1'b0; act1 = 1'b0; gaps = 1'b0;
        req0_i = 1'b0; req1_i = 1'b0; we0_i = 1'b0; we1_i = 1'b0;
        addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0; wstrb0_i = '0; wstrb1_i = '0;
        cyc = 0; n_chk = 0; n_err = 0; rv0_cnt = 0; rv1_cnt = 0; mptr = 1'b0;
        last0 = '0; last1 = '0; obs_rd1 = '0;
        @(posedge ACLK); #1;
        reset_for(2);

        // Contended writes right after reset.
        glog.delete();
        q0.push_back(mk(1, 'h004, 32'hA0A0_0004, 4'hF));
        q1.push_back(mk(1, 'h008, 32'hB0B0_0008, 4'hF));
        drain(3);
        check("wr_grant_count", 64'(glog.size()), 64'(2));
        check("wr_first_gnt", 64'(glog[0]), 64'(0));
        check("wr_second_gnt", 64'(glog[1]), 64'(1));

        // Writes by requester 0, burst read-back by requester 1.
        for (int i = 0; i < 4; i++) q0.push_back(mk(1, i, DW'(i + 1), 4'hF));
        drain(2);
        rv1_cnt = 0;
        for (int i = 0; i < 4; i++) q1.push_back(mk(0, i, '0, '0));
        drain(4);
        check("rd_burst_pulses", 64'(rv1_cnt), 64'(4));
        check("rd_burst_last", 64'(obs_rd1), 64'(4));

        // Both requesters reading continuously.
        glog.delete();
        for (int i = 0; i < 5; i++) begin
            q0.push_back(mk(0, i, '0, '0));
            q1.push_back(mk(0, 4 - i, '0, '0));
        end
        drain(4);
        c0 = 0; c1 = 0;
        foreach (glog[i]) if (glog[i] == 0) c0++; else c1++;
        check("alt_gnt0_count", 64'(c0), 64'(5));
        check("alt_gnt1_count", 64'(c1), 64'(5));
        for (int i = 1; i < glog.size(); i++)
            check("alt_order", 64'(glog[i] != glog[i-1]), 64'(1));

        // Partial-strobe write merges with existing word.
        q1.push_back(mk(1, 'h010, 32'h1122_3344, 4'hF));
        q1.push_back(mk(1, 'h010, 32'hAABB_CCDD, 4'h3));
        q1.push_back(mk(0, 'h010, '0, '0));
        drain(4);
        check("strobe_merge", 64'(obs_rd1), 64'(32'h1122_CCDD));

        // Leave the pointer favouring requester 1, then reset behind a read.
        q0.push_back(mk(1, 'h020, 32'h5, 4'hF));
        q1.push_back(mk(1, 'h021, 32'h6, 4'hF));
        drain(0);
        q0.push_back(mk(0, 'h000, '0, '0));
        step();
        rv_before = rv0_cnt;
        reset_for(1);
        repeat (3) step();
        check("rst_no_rvalid", 64'(rv0_cnt), 64'(rv_before));
        glog.delete();
        q0.push_back(mk(1, 'h030, 32'h7, 4'hF));
        q1.push_back(mk(1, 'h031, 32'h8, 4'hF));
        drain(2);
        check("post_rst_first_gnt", 64'(glog[0]), 64'(0));

        // Randomized traffic with idle gaps and occasional resets.
        gaps = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 3)
                q0.push_back(mk(1'($urandom), int'($urandom_range(0, 15)), $urandom, SW'($urandom)));
            if (q1.size() < 3)
                q1.push_back(mk(1'($urandom), int'($urandom_range(0, 15)), $urandom, SW'($urandom)));
            ARESET = ($urandom_range(0, 99) == 0);
            step();
        end
        ARESET = 1'b0;
        drain(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
